hilo_commit: RTL and testbench

HI/LO architectural register unit sitting directly downstream of the execute stage. It captures multiply/divide results and MTHI/MTLO writes leaving EXE and carries them through a two-entry MEM/WB pipeline. It commits them, including MADD/MADDU/MSUB/MSUBU 64-bit accumulation, only when the exception logic permits. It also returns forwarded HI/LO values to MFHI/MFLO in EXE and stalls EXE when a forward is not possible.

---
 rtl/hilo_commit.sv | 144 ++++++++++++++
 tb/tb_hilo_commit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit.sv
// HI/LO commit unit: two-entry MEM/WB pipeline for mult/div and MTHI/MTLO results,
// newest-first forwarding to MFHI/MFLO. Define HILO_ACCUM_EN to honour MADD/MSUB accumulation.
module hilo_commit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EXE_Finish,
    input  logic [31:0] EXE_MULTDIVtoHI,
    input  logic [31:0] EXE_MULTDIVtoLO,
    input  logic [1:0]  EXE_MultiExtendOp,
    input  logic        EXE_MTHI,
    input  logic        EXE_MTLO,
    input  logic [31:0] EXE_BusA_L1,
    input  logic [1:0]  EXE_ReadHiLo,
    input  logic        MEM_Wr,
    input  logic        MEM_Flush,
    input  logic        HiLo_Not_Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] EXE_HiLoRead,
    output logic        HiLo_Stall
);

    typedef struct packed {
        logic        valid;
        logic        hiwe;
        logic        lowe;
        logic [1:0]  acc;
        logic [31:0] hi;
        logic [31:0] lo;
    } entry_t;

    entry_t      cap, m_q, m_d, w_q, w_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [1:0]  acc_op;

`ifdef HILO_ACCUM_EN
    assign acc_op = (EXE_MultiExtendOp == 2'b11) ? 2'b00 : EXE_MultiExtendOp;
`else
    logic op_unused;
    assign op_unused = ^EXE_MultiExtendOp;
    assign acc_op    = 2'b00;
`endif

    always_comb begin
        cap = '0;
        if (EXE_Finish) begin
            cap.valid = 1'b1;
            cap.hiwe  = 1'b1;
            cap.lowe  = 1'b1;
            cap.acc   = acc_op;
            cap.hi    = EXE_MULTDIVtoHI;
            cap.lo    = EXE_MULTDIVtoLO;
        end else if (EXE_MTHI || EXE_MTLO) begin
            cap.valid = 1'b1;
            cap.hiwe  = EXE_MTHI;
            cap.lowe  = EXE_MTLO;
            cap.hi    = EXE_BusA_L1;
            cap.lo    = EXE_BusA_L1;
        end
    end

    // W is valid for exactly one cycle when the pipe stalls, so it commits once.
    always_comb begin
        m_d = MEM_Wr ? cap : m_q;
        if (MEM_Flush)
            m_d.valid = 1'b0;
        w_d       = w_q;
        w_d.valid = 1'b0;
        if (MEM_Wr)
            w_d = m_q;
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (w_q.valid && HiLo_Not_Flush) begin
`ifdef HILO_ACCUM_EN
            case (w_q.acc)
                2'b01:   {hi_d, lo_d} = {hi_q, lo_q} + {w_q.hi, w_q.lo};
                2'b10:   {hi_d, lo_d} = {hi_q, lo_q} - {w_q.hi, w_q.lo};
                default: begin
                    if (w_q.hiwe) hi_d = w_q.hi;
                    if (w_q.lowe) lo_d = w_q.lo;
                end
            endcase
`else
            if (w_q.hiwe) hi_d = w_q.hi;
            if (w_q.lowe) lo_d = w_q.lo;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_q  <= '0;
            w_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            m_q  <= m_d;
            w_q  <= w_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    logic       rd_hi, rd_lo, m_hit, w_hit, hit;
    logic [1:0] hit_acc;

    assign rd_hi = (EXE_ReadHiLo == 2'b01);
    assign rd_lo = (EXE_ReadHiLo == 2'b10);
    assign m_hit = m_q.valid && ((rd_hi && m_q.hiwe) || (rd_lo && m_q.lowe));
    assign w_hit = w_q.valid && ((rd_hi && w_q.hiwe) || (rd_lo && w_q.lowe));
    assign hit   = m_hit || w_hit;

    // Newest writer of the requested half wins; an accumulate writer has no value yet.
    always_comb begin
        EXE_HiLoRead = '0;
        hit_acc      = 2'b00;
        if (m_hit) begin
            hit_acc = m_q.acc;
            if (m_q.acc == 2'b00)
                EXE_HiLoRead = rd_hi ? m_q.hi : m_q.lo;
        end else if (w_hit) begin
            hit_acc = w_q.acc;
            if (w_q.acc == 2'b00)
                EXE_HiLoRead = rd_hi ? w_q.hi : w_q.lo;
        end else if (rd_hi) begin
            EXE_HiLoRead = hi_q;
        end else if (rd_lo) begin
            EXE_HiLoRead = lo_q;
        end
    end

`ifdef HILO_ACCUM_EN
    assign HiLo_Stall = hit && (hit_acc != 2'b00);
`else
    assign HiLo_Stall = 1'b0;
`endif

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_hilo_commit.sv
// Scoreboard bench for hilo_commit: directed scenarios then random traffic,
// checked against a 64-bit architectural model with a two-slot pending list.
module tb_hilo_commit;

    logic        clk = 1'b0;
    logic        resetn, EXE_Finish, EXE_MTHI, EXE_MTLO, MEM_Wr, MEM_Flush, HiLo_Not_Flush;
    logic [31:0] EXE_MULTDIVtoHI, EXE_MULTDIVtoLO, EXE_BusA_L1;
    logic [1:0]  EXE_MultiExtendOp, EXE_ReadHiLo;
    logic [31:0] HI, LO, EXE_HiLoRead;
    logic        HiLo_Stall;

    always #5 clk = ~clk;

    hilo_commit dut (
        .clk(clk), .resetn(resetn), .EXE_Finish(EXE_Finish),
        .EXE_MULTDIVtoHI(EXE_MULTDIVtoHI), .EXE_MULTDIVtoLO(EXE_MULTDIVtoLO),
        .EXE_MultiExtendOp(EXE_MultiExtendOp), .EXE_MTHI(EXE_MTHI), .EXE_MTLO(EXE_MTLO),
        .EXE_BusA_L1(EXE_BusA_L1), .EXE_ReadHiLo(EXE_ReadHiLo), .MEM_Wr(MEM_Wr),
        .MEM_Flush(MEM_Flush), .HiLo_Not_Flush(HiLo_Not_Flush), .HI(HI), .LO(LO),
        .EXE_HiLoRead(EXE_HiLoRead), .HiLo_Stall(HiLo_Stall)
    );

    typedef struct {
        bit        rstn, fin, mthi, mtlo, wr, fl, nf;
        bit [31:0] mhi, mlo, busa;
        bit [1:0]  op, rd;
    } stim_t;

    typedef struct {
        bit [1:0]  rd;
        bit [31:0] hi, lo, rdv;
        bit        st;
    } exp_t;

    typedef struct {
        bit        v, hw, lw;
        bit [1:0]  acc;
        bit [31:0] h, l;
    } ent_t;

    int    errors = 0;
    int    checks = 0;
    exp_t  expq[$];
    ent_t  pend[2];      // [0] newest (MEM), [1] oldest (WB)
    bit [63:0] arch;
`ifdef HILO_ACCUM_EN
    bit accum_on = 1'b1;
`else
    bit accum_on = 1'b0;
`endif

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s = '{default: 0};
        s.rstn = 1'b1;
        s.wr   = 1'b1;
        s.nf   = 1'b1;
        return s;
    endfunction

    // Read result: newest pending writer of that half, else architectural value.
    function automatic void model_out(input bit [1:0] rd, output bit [31:0] v, output bit st);
        bit found;
        bit want;
        v = 32'h0;
        st = 1'b0;
        found = 1'b0;
        if (rd == 2'b01 || rd == 2'b10) begin
            for (int i = 0; i < 2; i++) begin
                want = (rd == 2'b01) ? pend[i].hw : pend[i].lw;
                if (!found && pend[i].v && want) begin
                    found = 1'b1;
                    if (pend[i].acc != 2'b00) st = 1'b1;
                    else v = (rd == 2'b01) ? pend[i].h : pend[i].l;
                end
            end
            if (!found) v = (rd == 2'b01) ? arch[63:32] : arch[31:0];
        end
    endfunction

    function automatic void model_edge(input stim_t s);
        ent_t nm;
        if (!s.rstn) begin
            arch = 64'h0;
            pend[0].v = 1'b0;
            pend[1].v = 1'b0;
            return;
        end
        if (pend[1].v && s.nf) begin
            case (pend[1].acc)
                2'b01:   arch = arch + {pend[1].h, pend[1].l};
                2'b10:   arch = arch - {pend[1].h, pend[1].l};
                default: begin
                    if (pend[1].hw) arch[63:32] = pend[1].h;
                    if (pend[1].lw) arch[31:0]  = pend[1].l;
                end
            endcase
        end
        nm = pend[0];
        if (s.wr) begin
            nm = '{default: 0};
            if (s.fin) begin
                nm.v = 1'b1; nm.hw = 1'b1; nm.lw = 1'b1;
                nm.acc = (accum_on && s.op != 2'b11) ? s.op : 2'b00;
                nm.h = s.mhi; nm.l = s.mlo;
            end else if (s.mthi || s.mtlo) begin
                nm.v = 1'b1; nm.hw = s.mthi; nm.lw = s.mtlo;
                nm.h = s.busa; nm.l = s.busa;
            end
        end
        if (s.fl) nm.v = 1'b0;
        if (s.wr) pend[1] = pend[0];
        else      pend[1].v = 1'b0;
        pend[0] = nm;
    endfunction

    // Starts at posedge+1, drives one cycle, ends at the following posedge+1.
    task automatic step(input stim_t s);
        exp_t e;
        resetn = s.rstn; EXE_Finish = s.fin; EXE_MULTDIVtoHI = s.mhi; EXE_MULTDIVtoLO = s.mlo;
        EXE_MultiExtendOp = s.op; EXE_MTHI = s.mthi; EXE_MTLO = s.mtlo; EXE_BusA_L1 = s.busa;
        EXE_ReadHiLo = s.rd; MEM_Wr = s.wr; MEM_Flush = s.fl; HiLo_Not_Flush = s.nf;
        e.rd = s.rd;
        e.hi = arch[63:32];
        e.lo = arch[31:0];
        model_out(s.rd, e.rdv, e.st);
        expq.push_back(e);
        model_edge(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(idle_s());
    endtask

    function automatic bit [31:0] rv();
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("HI", HI, e.hi);
                chk("LO", LO, e.lo);
                chk("stall", {31'b0, HiLo_Stall}, {31'b0, e.st});
                if ((e.rd == 2'b01 || e.rd == 2'b10) && !e.st)
                    chk("read", EXE_HiLoRead, e.rdv);
            end
        end
    end

    initial begin : driver
        stim_t s;
        resetn = 1'b0; EXE_Finish = 1'b0; EXE_MULTDIVtoHI = '0; EXE_MULTDIVtoLO = '0;
        EXE_MultiExtendOp = '0; EXE_MTHI = 1'b0; EXE_MTLO = 1'b0; EXE_BusA_L1 = '0;
        EXE_ReadHiLo = '0; MEM_Wr = 1'b0; MEM_Flush = 1'b0; HiLo_Not_Flush = 1'b1;
        arch = 64'h0;
        pend[0] = '{default: 0};
        pend[1] = '{default: 0};
        @(posedge clk);
        #1;

        s = idle_s(); s.rstn = 1'b0; s.fin = 1'b1; s.mhi = 32'hDEAD; s.mlo = 32'hBEEF;
        step(s); step(s);
        chk("reset_HI", HI, 32'h0);
        chk("reset_LO", LO, 32'h0);
        s = idle_s(); s.rd = 2'b01;
        step(s);

        // MULT then MFLO forwarded from MEM
        s = idle_s(); s.fin = 1'b1; s.mhi = 32'h1; s.mlo = 32'hFFFF_FFFF;
        step(s);
        s = idle_s(); s.rd = 2'b10;
        step(s);
        chk("mult_LO_not_yet", LO, 32'h0);
        idle(1);
        chk("mult_LO", LO, 32'hFFFF_FFFF);
        chk("mult_HI", HI, 32'h1);

`ifdef HILO_ACCUM_EN
        s = idle_s(); s.mthi = 1'b1; s.busa = 32'h0;
        step(s);
        s = idle_s(); s.fin = 1'b1; s.op = 2'b01; s.mhi = 32'h0; s.mlo = 32'h1;
        step(s);
        s = idle_s(); s.rd = 2'b01;
        for (int k = 0; k < 10; k++) begin
            bit [31:0] v;
            bit st;
            model_out(s.rd, v, st);
            step(s);
            if (!st) break;
        end
        chk("madd_HI", HI, 32'h1);
        chk("madd_LO", LO, 32'h0);
        s = idle_s(); s.mthi = 1'b1; s.mtlo = 1'b1; s.busa = 32'h0;
        step(s);
        s = idle_s(); s.fin = 1'b1; s.op = 2'b10; s.mhi = 32'h0; s.mlo = 32'h1;
        step(s);
        idle(3);
        chk("msub_HI", HI, 32'hFFFF_FFFF);
        chk("msub_LO", LO, 32'hFFFF_FFFF);
`endif

        // Known state, then a dropped commit and a flushed capture
        s = idle_s(); s.mthi = 1'b1; s.busa = 32'h1111_1111; step(s);
        s = idle_s(); s.mtlo = 1'b1; s.busa = 32'h2222_2222; step(s);
        idle(2);
        s = idle_s(); s.mthi = 1'b1; s.busa = 32'hA5A5_A5A5; step(s);
        idle(1);
        s = idle_s(); s.nf = 1'b0; step(s);
        chk("nf0_HI", HI, 32'h1111_1111);
        s = idle_s(); s.mtlo = 1'b1; s.busa = 32'h5; s.fl = 1'b1; step(s);
        idle(3);
        chk("flush_LO", LO, 32'h2222_2222);

        // MEM_Wr low for three cycles with an entry in WB
        s = idle_s(); s.mthi = 1'b1; s.busa = 32'h1234; step(s);
        s = idle_s(); s.mtlo = 1'b1; s.busa = 32'h77; step(s);
        s = idle_s(); s.wr = 1'b0; s.rd = 2'b10;
        step(s);
        chk("hold_HI", HI, 32'h1234);
        step(s); step(s);
        chk("hold_LO", LO, 32'h2222_2222);
        idle(2);
        chk("release_LO", LO, 32'h77);

        for (int n = 0; n < 3000; n++) begin
            s.rstn = ($urandom_range(63) != 0);
            s.fin  = ($urandom_range(3) == 0);
            s.mhi  = rv();
            s.mlo  = rv();
            s.op   = 2'($urandom_range(3));
            s.mthi = ($urandom_range(3) == 0);
            s.mtlo = ($urandom_range(3) == 0);
            s.busa = rv();
            s.rd   = 2'($urandom_range(3));
            s.wr   = ($urandom_range(7) != 0);
            s.fl   = ($urandom_range(9) == 0);
            s.nf   = ($urandom_range(7) != 0);
            step(s);
        end

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #1;
        if (expq.size() > 0) chk("drain", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
